// File: rtl/window_pkg.sv
// ============================================================================
// Module      : window_pkg
// Description : Shared constants and FSM state encoding for window_collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package window_pkg;

    localparam int C_MAX_IN = 8;
    localparam int C_IDX_W  = 3;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter8.sv
// ============================================================================
// Module      : rr_arbiter8
// Description : 8-way round-robin arbiter; searches upward from ptr_i+1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter8
    import window_pkg::*;
(
    input  logic [C_MAX_IN-1:0] valid_i,
    input  logic [C_IDX_W-1:0]  ptr_i,
    output logic [C_MAX_IN-1:0] grant_o,
    output logic [C_IDX_W-1:0]  idx_o,
    output logic                any_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = ptr_i;
        any_o   = 1'b0;
        // The last-granted port is visited last, giving it the lowest priority.
        for (int k = 1; k <= C_MAX_IN; k++) begin
            automatic logic [C_IDX_W-1:0] cand = ptr_i + C_IDX_W'(k);
            if (!any_o && valid_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/window_collector.sv
// ============================================================================
// Module      : window_collector
// Description : Accepts one window request by round-robin, holds it pending
//               and commits it to the m_* outputs on the next fsync.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_collector
    import window_pkg::*;
#(
    parameter int C_HBITS     = 12,
    parameter int C_WBITS     = 12,
    parameter int C_SLAVE_NUM = 1
)(
    input  logic               clk,
    input  logic               resetn,
    input  logic               fsync,
    input  logic [C_WBITS-1:0] s0_left,   input  logic [C_WBITS-1:0] s0_width,
    input  logic [C_HBITS-1:0] s0_top,    input  logic [C_HBITS-1:0] s0_height,
    input  logic               s0_valid,  output logic               s0_ready,
    input  logic [C_WBITS-1:0] s1_left,   input  logic [C_WBITS-1:0] s1_width,
    input  logic [C_HBITS-1:0] s1_top,    input  logic [C_HBITS-1:0] s1_height,
    input  logic               s1_valid,  output logic               s1_ready,
    input  logic [C_WBITS-1:0] s2_left,   input  logic [C_WBITS-1:0] s2_width,
    input  logic [C_HBITS-1:0] s2_top,    input  logic [C_HBITS-1:0] s2_height,
    input  logic               s2_valid,  output logic               s2_ready,
    input  logic [C_WBITS-1:0] s3_left,   input  logic [C_WBITS-1:0] s3_width,
    input  logic [C_HBITS-1:0] s3_top,    input  logic [C_HBITS-1:0] s3_height,
    input  logic               s3_valid,  output logic               s3_ready,
    input  logic [C_WBITS-1:0] s4_left,   input  logic [C_WBITS-1:0] s4_width,
    input  logic [C_HBITS-1:0] s4_top,    input  logic [C_HBITS-1:0] s4_height,
    input  logic               s4_valid,  output logic               s4_ready,
    input  logic [C_WBITS-1:0] s5_left,   input  logic [C_WBITS-1:0] s5_width,
    input  logic [C_HBITS-1:0] s5_top,    input  logic [C_HBITS-1:0] s5_height,
    input  logic               s5_valid,  output logic               s5_ready,
    input  logic [C_WBITS-1:0] s6_left,   input  logic [C_WBITS-1:0] s6_width,
    input  logic [C_HBITS-1:0] s6_top,    input  logic [C_HBITS-1:0] s6_height,
    input  logic               s6_valid,  output logic               s6_ready,
    input  logic [C_WBITS-1:0] s7_left,   input  logic [C_WBITS-1:0] s7_width,
    input  logic [C_HBITS-1:0] s7_top,    input  logic [C_HBITS-1:0] s7_height,
    input  logic               s7_valid,  output logic               s7_ready,
    output logic [C_WBITS-1:0] m_left,
    output logic [C_WBITS-1:0] m_width,
    output logic [C_HBITS-1:0] m_top,
    output logic [C_HBITS-1:0] m_height,
    output logic               m_update,
    output logic               m_pending,
    output logic               m_err
);

    localparam logic [C_IDX_W-1:0] C_PTR_RST = C_IDX_W'(C_SLAVE_NUM - 1);

    logic [C_WBITS-1:0]  w_left   [C_MAX_IN];
    logic [C_WBITS-1:0]  w_width  [C_MAX_IN];
    logic [C_HBITS-1:0]  w_top    [C_MAX_IN];
    logic [C_HBITS-1:0]  w_height [C_MAX_IN];
    logic [C_MAX_IN-1:0] w_valid_raw;
    logic [C_MAX_IN-1:0] w_req;
    logic [C_MAX_IN-1:0] w_grant;
    logic [C_IDX_W-1:0]  w_idx;
    logic                w_any;
    logic                w_win_ok;

    state_e              state_q;
    logic [C_IDX_W-1:0]  ptr_q;
    logic [C_WBITS-1:0]  pend_left_q,  pend_width_q,  m_left_q,  m_width_q;
    logic [C_HBITS-1:0]  pend_top_q,   pend_height_q, m_top_q,   m_height_q;
    logic                m_update_q, m_err_q;

    assign w_left   = '{s0_left,   s1_left,   s2_left,   s3_left,
                        s4_left,   s5_left,   s6_left,   s7_left};
    assign w_width  = '{s0_width,  s1_width,  s2_width,  s3_width,
                        s4_width,  s5_width,  s6_width,  s7_width};
    assign w_top    = '{s0_top,    s1_top,    s2_top,    s3_top,
                        s4_top,    s5_top,    s6_top,    s7_top};
    assign w_height = '{s0_height, s1_height, s2_height, s3_height,
                        s4_height, s5_height, s6_height, s7_height};
    assign w_valid_raw = {s7_valid, s6_valid, s5_valid, s4_valid,
                          s3_valid, s2_valid, s1_valid, s0_valid};

    // Unused ports and the whole PENDING state are hidden from the arbiter.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < C_MAX_IN; i++) begin
            w_req[i] = w_valid_raw[i] && (i < C_SLAVE_NUM) && (state_q == ST_IDLE);
        end
    end

    rr_arbiter8 u_arb (
        .valid_i (w_req),
        .ptr_i   (ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_idx),
        .any_o   (w_any)
    );

    assign {s7_ready, s6_ready, s5_ready, s4_ready,
            s3_ready, s2_ready, s1_ready, s0_ready} = w_grant;

    assign w_win_ok = (w_width[w_idx] != '0) && (w_height[w_idx] != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            ptr_q         <= C_PTR_RST;
            pend_left_q   <= '0;
            pend_width_q  <= '0;
            pend_top_q    <= '0;
            pend_height_q <= '0;
            m_left_q      <= '0;
            m_width_q     <= '0;
            m_top_q       <= '0;
            m_height_q    <= '0;
            m_update_q    <= 1'b0;
            m_err_q       <= 1'b0;
        end else begin
            m_update_q <= 1'b0;
            m_err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // fsync is ignored here, so an accept in the same cycle waits for the next one.
                    if (w_any) begin
                        ptr_q <= w_idx;
                        if (w_win_ok) begin
                            pend_left_q   <= w_left[w_idx];
                            pend_width_q  <= w_width[w_idx];
                            pend_top_q    <= w_top[w_idx];
                            pend_height_q <= w_height[w_idx];
                            state_q       <= ST_PENDING;
                        end else begin
                            m_err_q <= 1'b1;
                        end
                    end
                end
                ST_PENDING: begin
                    if (fsync) begin
                        m_left_q   <= pend_left_q;
                        m_width_q  <= pend_width_q;
                        m_top_q    <= pend_top_q;
                        m_height_q <= pend_height_q;
                        m_update_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_left    = m_left_q;
    assign m_width   = m_width_q;
    assign m_top     = m_top_q;
    assign m_height  = m_height_q;
    assign m_update  = m_update_q;
    assign m_err     = m_err_q;
    assign m_pending = (state_q == ST_PENDING);

endmodule

`default_nettype wire

// File: tb/tb_window_collector.sv
// ============================================================================
// Module      : tb_window_collector
// Description : Self-checking bench for window_collector with C_SLAVE_NUM=2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_window_collector;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        fsync = 1'b0;
    logic [11:0] t_left   [8];
    logic [11:0] t_width  [8];
    logic [11:0] t_top    [8];
    logic [11:0] t_height [8];
    logic [7:0]  t_valid = 8'h00;
    wire  [7:0]  t_ready;
    wire  [11:0] m_left, m_width, m_top, m_height;
    wire         m_update, m_pending, m_err;

    always #5 clk = ~clk;

    window_collector #(.C_HBITS(12), .C_WBITS(12), .C_SLAVE_NUM(N)) dut (
        .clk(clk), .resetn(resetn), .fsync(fsync),
        .s0_left(t_left[0]), .s0_width(t_width[0]), .s0_top(t_top[0]), .s0_height(t_height[0]),
        .s0_valid(t_valid[0]), .s0_ready(t_ready[0]),
        .s1_left(t_left[1]), .s1_width(t_width[1]), .s1_top(t_top[1]), .s1_height(t_height[1]),
        .s1_valid(t_valid[1]), .s1_ready(t_ready[1]),
        .s2_left(t_left[2]), .s2_width(t_width[2]), .s2_top(t_top[2]), .s2_height(t_height[2]),
        .s2_valid(t_valid[2]), .s2_ready(t_ready[2]),
        .s3_left(t_left[3]), .s3_width(t_width[3]), .s3_top(t_top[3]), .s3_height(t_height[3]),
        .s3_valid(t_valid[3]), .s3_ready(t_ready[3]),
        .s4_left(t_left[4]), .s4_width(t_width[4]), .s4_top(t_top[4]), .s4_height(t_height[4]),
        .s4_valid(t_valid[4]), .s4_ready(t_ready[4]),
        .s5_left(t_left[5]), .s5_width(t_width[5]), .s5_top(t_top[5]), .s5_height(t_height[5]),
        .s5_valid(t_valid[5]), .s5_ready(t_ready[5]),
        .s6_left(t_left[6]), .s6_width(t_width[6]), .s6_top(t_top[6]), .s6_height(t_height[6]),
        .s6_valid(t_valid[6]), .s6_ready(t_ready[6]),
        .s7_left(t_left[7]), .s7_width(t_width[7]), .s7_top(t_top[7]), .s7_height(t_height[7]),
        .s7_valid(t_valid[7]), .s7_ready(t_ready[7]),
        .m_left(m_left), .m_width(m_width), .m_top(m_top), .m_height(m_height),
        .m_update(m_update), .m_pending(m_pending), .m_err(m_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: abstract window-holder state.
    bit          exp_pend;
    logic [11:0] pend_l, pend_w, pend_t, pend_h;
    logic [11:0] exp_l, exp_w, exp_t, exp_h;
    bit          exp_upd, exp_err;
    int          last;
    logic [7:0]  seen_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    // Next port after the last winner, counting around the N live ports only.
    function automatic int pick();
        if (exp_pend) return -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (t_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_pend = 0; exp_upd = 0; exp_err = 0; last = N - 1;
        pend_l = 0; pend_w = 0; pend_t = 0; pend_h = 0;
        exp_l = 0; exp_w = 0; exp_t = 0; exp_h = 0;
    endtask

    task automatic model_edge(input int g, input bit fs);
        exp_upd = 0;
        exp_err = 0;
        if (exp_pend) begin
            if (fs) begin
                exp_l = pend_l; exp_w = pend_w; exp_t = pend_t; exp_h = pend_h;
                exp_upd = 1; exp_pend = 0;
            end
        end else if (g >= 0) begin
            last = g;
            if (t_width[g] != 0 && t_height[g] != 0) begin
                pend_l = t_left[g]; pend_w = t_width[g];
                pend_t = t_top[g];  pend_h = t_height[g];
                exp_pend = 1;
            end else begin
                exp_err = 1;
            end
        end
    endtask

    task automatic check_pre(input int g);
        for (int i = 0; i < 8; i++) check($sformatf("ready%0d", i), 32'(t_ready[i]), 32'(i == g));
    endtask

    task automatic check_post();
        check("m_left",    32'(m_left),    32'(exp_l));
        check("m_width",   32'(m_width),   32'(exp_w));
        check("m_top",     32'(m_top),     32'(exp_t));
        check("m_height",  32'(m_height),  32'(exp_h));
        check("m_update",  32'(m_update),  32'(exp_upd));
        check("m_err",     32'(m_err),     32'(exp_err));
        check("m_pending", 32'(m_pending), 32'(exp_pend));
    endtask

    task automatic step(input bit fs);
        int g;
        @(negedge clk);
        fsync = fs;
        #1;
        g = pick();
        seen_ready = t_ready;
        check_pre(g);
        @(posedge clk);
        model_edge(g, fs);
        #1;
        check_post();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        fsync  = 1'b0;
        #1;
        model_reset();
        check_post();
        @(posedge clk);
        #1;
        check_post();
        resetn = 1'b1;
    endtask

    task automatic set_win(input int p, input int l, input int w, input int t, input int h);
        t_left[p] = 12'(l); t_width[p] = 12'(w); t_top[p] = 12'(t); t_height[p] = 12'(h);
    endtask

    initial begin
        int grants[$];
        for (int i = 0; i < 8; i++) set_win(i, 0, 0, 0, 0);
        model_reset();
        do_reset();

        // Basic accept then commit.
        set_win(0, 10, 100, 20, 50);
        t_valid = 8'h01;
        step(0);
        check("lit_s0_ready", 32'(seen_ready), 32'h01);
        check("lit_pending", 32'(m_pending), 1);
        t_valid = 8'h00;
        step(1);
        check("lit_m_left", 32'(m_left), 10);
        check("lit_m_width", 32'(m_width), 100);
        check("lit_m_top", 32'(m_top), 20);
        check("lit_m_height", 32'(m_height), 50);
        check("lit_m_update", 32'(m_update), 1);
        step(0);
        check("lit_update_once", 32'(m_update), 0);

        // Zero-width request is accepted and dropped.
        set_win(1, 7, 0, 3, 9);
        t_valid = 8'h02;
        step(0);
        check("lit_s1_ready", 32'(seen_ready), 32'h02);
        check("lit_m_err", 32'(m_err), 1);
        check("lit_err_pending", 32'(m_pending), 0);
        check("lit_err_hold", 32'(m_left), 10);
        t_valid = 8'h00;
        step(0);
        check("lit_err_once", 32'(m_err), 0);

        // Accept coinciding with fsync waits for the next fsync.
        set_win(0, 1, 5, 2, 5);
        t_valid = 8'h01;
        step(1);
        check("lit_same_cyc_noupd", 32'(m_update), 0);
        t_valid = 8'h00;
        step(0);
        check("lit_still_noupd", 32'(m_update), 0);
        step(1);
        check("lit_next_upd", 32'(m_update), 1);
        check("lit_next_left", 32'(m_left), 1);

        // Unused port is ignored; reset in PENDING discards the window.
        set_win(5, 4, 4, 4, 4);
        t_valid = 8'h20;
        step(0);
        check("lit_s5_ready", 32'(seen_ready), 0);
        t_valid = 8'h21;
        set_win(0, 33, 44, 55, 66);
        step(0);
        check("lit_pend_pre_rst", 32'(m_pending), 1);
        t_valid = 8'h00;
        do_reset();
        check("lit_rst_left", 32'(m_left), 0);
        check("lit_rst_pending", 32'(m_pending), 0);
        step(1);
        check("lit_rst_noupd", 32'(m_update), 0);

        // Fairness: both ports valid, fsync every 4 cycles.
        set_win(0, 1, 1, 1, 1);
        set_win(1, 2, 2, 2, 2);
        t_valid = 8'h03;
        for (int c = 0; c < 16; c++) begin
            step(c % 4 == 3);
            for (int i = 0; i < 8; i++) if (seen_ready[i]) grants.push_back(i);
        end
        check("lit_rr_count", 32'(grants.size()), 4);
        if (grants.size() == 4) begin
            check("lit_rr_g0", 32'(grants[0]), 0);
            check("lit_rr_g1", 32'(grants[1]), 1);
            check("lit_rr_g2", 32'(grants[2]), 0);
            check("lit_rr_g3", 32'(grants[3]), 1);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            t_valid = 8'($urandom);
            for (int i = 0; i < 8; i++) begin
                set_win(i, $urandom_range(0, 4095),
                        ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 4095),
                        $urandom_range(0, 4095),
                        ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 4095));
            end
            if ($urandom_range(0, 99) == 0) do_reset();
            else step($urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
